phy_bmc_tx: RTL and testbench



---
 rtl/phy_bmc_tx_if.sv | 22 ++
 rtl/phy_bmc_tx.sv | 179 +++++++++++++++++
 tb/tb_phy_bmc_tx.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phy_bmc_tx_if.sv
// Symbol stream from the PHY TX encoder into the BMC transmitter.
// The master drives symbols and the slave (the transmitter) pulses ready when it consumes one.
interface phy_bmc_tx_if;
    logic [4:0] phy_tx_sym_data;
    logic       phy_tx_sym_valid;
    logic       phy_tx_sym_last;
    logic       phy_tx_sym_ready;

    modport master (
        output phy_tx_sym_data,
        output phy_tx_sym_valid,
        output phy_tx_sym_last,
        input  phy_tx_sym_ready
    );

    modport slave (
        input  phy_tx_sym_data,
        input  phy_tx_sym_valid,
        input  phy_tx_sym_last,
        output phy_tx_sym_ready
    );
endinterface

// File: rtl/phy_bmc_tx.sv
// BMC transmitter for the PD CC line: preamble, LSB-first symbol serialization, trailing edge and hold-low.
// Optional macro PHY_TX_IDLE_GATE_EN adds phy_tx_line_idle and a WAIT_IDLE state ahead of the preamble.
module phy_bmc_tx #(
    parameter int HALF_BIT_CYCLES   = 8,
    parameter int PREAMBLE_BITS     = 64,
    parameter int HOLD_LOW_HALFBITS = 2,
    parameter int IDLE_WAIT_MAX     = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    phy_bmc_tx_if.slave       sym,
    input  logic              phy_tx_en,
`ifdef PHY_TX_IDLE_GATE_EN
    input  logic              phy_tx_line_idle,
`endif
    output logic              phy_tx_cc_signal,
    output logic              phy_tx_cc_oe,
    output logic              phy_tx_busy,
    output logic              phy_tx_done,
    output logic              phy_tx_result
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PREAMBLE  = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_TRAIL     = 3'd3;
    localparam logic [2:0] ST_HOLD      = 3'd4;
`ifdef PHY_TX_IDLE_GATE_EN
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;
`endif

    // One half-bit counter serves preamble, symbol, hold and idle-wait phases, so size it for the longest.
    localparam int HB_SPAN = (2 * PREAMBLE_BITS > IDLE_WAIT_MAX) ? 2 * PREAMBLE_BITS : IDLE_WAIT_MAX;
    localparam int HB_W    = $clog2(HB_SPAN + HOLD_LOW_HALFBITS + 16);

    localparam logic [7:0]      HALF_LAST = 8'(HALF_BIT_CYCLES - 1);
    localparam logic [HB_W-1:0] PRE_LAST  = HB_W'(2 * PREAMBLE_BITS - 1);
    localparam logic [HB_W-1:0] SYM_LAST  = HB_W'(9);
    localparam logic [HB_W-1:0] HOLD_LAST = HB_W'(HOLD_LOW_HALFBITS - 1);
`ifdef PHY_TX_IDLE_GATE_EN
    localparam logic [HB_W-1:0] WAIT_LAST = HB_W'(IDLE_WAIT_MAX - 1);
`endif

    logic [2:0]      state;
    logic [7:0]      half_cnt;
    logic [HB_W-1:0] hb_cnt;
    logic [4:0]      sym_reg;
    logic            last_reg;

    logic tick;
    logic pre_end;
    logic sym_end;
    logic fetch;
    logic sym_bit;
    logic mid_toggle;

    assign tick    = (state != ST_IDLE) && (half_cnt == HALF_LAST);
    assign pre_end = (state == ST_PREAMBLE) && (hb_cnt == PRE_LAST);
    assign sym_end = (state == ST_DATA) && (hb_cnt == SYM_LAST);
    assign fetch   = tick && (pre_end || (sym_end && !last_reg));
    assign sym_bit = sym_reg[hb_cnt[3:1]];

    // Odd half-bit counts end a bit (always toggle); even ones toggle mid-bit only for a 1.
    assign mid_toggle = hb_cnt[0] || ((state == ST_PREAMBLE) ? hb_cnt[1] : sym_bit);

    assign sym.phy_tx_sym_ready = fetch && sym.phy_tx_sym_valid;
    assign phy_tx_busy          = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            half_cnt         <= '0;
            hb_cnt           <= '0;
            sym_reg          <= '0;
            last_reg         <= 1'b0;
            phy_tx_cc_signal <= 1'b0;
            phy_tx_cc_oe     <= 1'b0;
            phy_tx_done      <= 1'b0;
            phy_tx_result    <= 1'b0;
        end else begin
            phy_tx_done <= 1'b0;
            if (state != ST_IDLE) begin
                half_cnt <= tick ? '0 : half_cnt + 8'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (phy_tx_en) begin
                        phy_tx_result <= 1'b0;
                        half_cnt      <= '0;
                        hb_cnt        <= '0;
`ifdef PHY_TX_IDLE_GATE_EN
                        state         <= ST_WAIT_IDLE;
`else
                        state            <= ST_PREAMBLE;
                        phy_tx_cc_oe     <= 1'b1;
                        phy_tx_cc_signal <= 1'b1;
`endif
                    end
                end

`ifdef PHY_TX_IDLE_GATE_EN
                ST_WAIT_IDLE: begin
                    if (phy_tx_line_idle) begin
                        state            <= ST_PREAMBLE;
                        half_cnt         <= '0;
                        hb_cnt           <= '0;
                        phy_tx_cc_oe     <= 1'b1;
                        phy_tx_cc_signal <= 1'b1;
                    end else if (tick) begin
                        if (hb_cnt == WAIT_LAST) begin
                            state         <= ST_IDLE;
                            hb_cnt        <= '0;
                            phy_tx_done   <= 1'b1;
                            phy_tx_result <= 1'b0;
                        end else begin
                            hb_cnt <= hb_cnt + HB_W'(1);
                        end
                    end
                end
`endif

                ST_PREAMBLE, ST_DATA: begin
                    if (tick) begin
                        if (fetch && sym.phy_tx_sym_valid) begin
                            sym_reg          <= sym.phy_tx_sym_data;
                            last_reg         <= sym.phy_tx_sym_last;
                            state            <= ST_DATA;
                            hb_cnt           <= '0;
                            phy_tx_cc_signal <= ~phy_tx_cc_signal;
                        end else if (pre_end || sym_end) begin
                            // Underrun when a fetch found nothing, clean end after a last symbol.
                            phy_tx_result <= !fetch;
                            hb_cnt        <= '0;
                            if (phy_tx_cc_signal) begin
                                state            <= ST_TRAIL;
                                phy_tx_cc_signal <= 1'b0;
                            end else begin
                                state <= ST_HOLD;
                            end
                        end else begin
                            hb_cnt <= hb_cnt + HB_W'(1);
                            if (mid_toggle) begin
                                phy_tx_cc_signal <= ~phy_tx_cc_signal;
                            end
                        end
                    end
                end

                ST_TRAIL: begin
                    if (tick) begin
                        state  <= ST_HOLD;
                        hb_cnt <= '0;
                    end
                end

                ST_HOLD: begin
                    if (tick) begin
                        if (hb_cnt == HOLD_LAST) begin
                            state        <= ST_IDLE;
                            hb_cnt       <= '0;
                            phy_tx_cc_oe <= 1'b0;
                            phy_tx_done  <= 1'b1;
                        end else begin
                            hb_cnt <= hb_cnt + HB_W'(1);
                        end
                    end
                end

                default: begin
                    state            <= ST_IDLE;
                    phy_tx_cc_oe     <= 1'b0;
                    phy_tx_cc_signal <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phy_bmc_tx.sv
// Directed self-checking bench for phy_bmc_tx: timing from oe rise, sym_ready positions and BMC decode of the line.
// Cycle 0 is the first cycle with oe high; expected numbers are derived for HALF_BIT_CYCLES=8, PREAMBLE_BITS=64.
module tb_phy_bmc_tx;
    localparam int H = 8;
`ifdef PHY_TX_IDLE_GATE_EN
    localparam int EXP_LAT = 2;
`else
    localparam int EXP_LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic line_idle = 1'b1;
    logic cc, oe, busy, done, result;

    int compare_count = 0;
    int mismatch_count = 0;

    logic [4:0] sym_tab[$];
    logic       last_tab[$];
    logic       line_q[$];
    logic       exp_bits[$];
    int         ready_pos[$];
    int         sym_idx;
    int         done_at;
    int         latency;
    logic       done_result;
    logic       done_busy;

    phy_bmc_tx_if sym_bus ();

    phy_bmc_tx #(
        .HALF_BIT_CYCLES  (8),
        .PREAMBLE_BITS    (64),
        .HOLD_LOW_HALFBITS(2),
        .IDLE_WAIT_MAX    (64)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sym             (sym_bus),
        .phy_tx_en       (en),
`ifdef PHY_TX_IDLE_GATE_EN
        .phy_tx_line_idle(line_idle),
`endif
        .phy_tx_cc_signal(cc),
        .phy_tx_cc_oe    (oe),
        .phy_tx_busy     (busy),
        .phy_tx_done     (done),
        .phy_tx_result   (result)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input int observed, input int expected);
        compare_count++;
        assert (observed === expected) else begin
            mismatch_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic drive_symbol(input logic vmode);
        sym_bus.phy_tx_sym_data  = sym_tab[sym_idx];
        sym_bus.phy_tx_sym_last  = last_tab[sym_idx];
        sym_bus.phy_tx_sym_valid = vmode;
    endtask

    // Starts a frame and records line samples, ready positions and the done cycle relative to oe rise.
    task automatic apply_stimulus(input int nsym, input logic vmode, input int poke_at);
        bit advance = 1'b0;
        sym_idx = 0;
        drive_symbol(vmode);
        line_q.delete();
        ready_pos.delete();
        done_at = -1;
        done_result = 1'b0;
        done_busy = 1'b1;
        en = 1'b1;
        step();
        en = 1'b0;
        latency = 1;
        while (!oe && latency < 8) begin
            step();
            latency++;
        end
        for (int n = 0; n < 4000; n++) begin
            if (advance) begin
                advance = 1'b0;
                if (sym_idx < nsym - 1) sym_idx++;
                drive_symbol(vmode);
            end
            en = (n == poke_at);
            if (done) begin
                done_at = n;
                done_result = result;
                done_busy = busy;
                break;
            end
            if (oe) line_q.push_back(cc);
            if (sym_bus.phy_tx_sym_ready) begin
                ready_pos.push_back(n);
                advance = 1'b1;
            end
            step();
        end
        en = 1'b0;
        sym_bus.phy_tx_sym_valid = 1'b0;
    endtask

    task automatic build_expected(input int nsym);
        logic [4:0] v;
        exp_bits.delete();
        for (int i = 0; i < 64; i++) exp_bits.push_back(logic'(i % 2));
        for (int s = 0; s < nsym; s++) begin
            v = sym_tab[s];
            for (int b = 0; b < 5; b++) begin
                exp_bits.push_back(v[0]);
                v = v >> 1;
            end
        end
    endtask

    // Independent BMC decode: each bit must start with a transition; a mid-bit transition means 1.
    task automatic decode_check(input string tag);
        int   errors = 0;
        logic prev = 1'b0;
        logic h0, h1;
        if (line_q.size() < exp_bits.size() * 2 * H) errors = 1000;
        else begin
            for (int i = 0; i < exp_bits.size(); i++) begin
                h0 = line_q[(2 * i) * H + H / 2];
                h1 = line_q[(2 * i + 1) * H + H / 2];
                if (h0 == prev) errors++;
                if ((h0 ^ h1) != exp_bits[i]) errors++;
                prev = h1;
            end
        end
        check_output(tag, errors, 0);
    endtask

    task automatic tail_check(input string tag, input int k);
        int ones = 0;
        if (line_q.size() < k) ones = 1000;
        else for (int i = line_q.size() - k; i < line_q.size(); i++) if (line_q[i]) ones++;
        check_output(tag, ones, 0);
    endtask

    initial begin
        int oe_seen;
        int done_count;
        int first_oe;
        sym_bus.phy_tx_sym_data  = 5'd0;
        sym_bus.phy_tx_sym_valid = 1'b0;
        sym_bus.phy_tx_sym_last  = 1'b0;

        step();
        step();
        check_output("rst_cc", int'(cc), 0);
        check_output("rst_oe", int'(oe), 0);
        check_output("rst_ready", int'(sym_bus.phy_tx_sym_ready), 0);
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_done", int'(done), 0);
        check_output("rst_result", int'(result), 0);
        rst_n = 1'b1;
        step();

        $display("[TB] single symbol 11111 last");
        sym_tab = '{5'b11111};
        last_tab = '{1'b1};
        apply_stimulus(1, 1'b1, -1);
        check_output("a_latency", latency, EXP_LAT);
        check_output("a_done_at", done_at, 1120);
        check_output("a_result", int'(done_result), 1);
        check_output("a_busy_at_done", int'(done_busy), 0);
        check_output("a_ready_count", ready_pos.size(), 1);
        if (ready_pos.size() > 0) check_output("a_ready_pos", ready_pos[0], 1023);
        build_expected(1);
        decode_check("a_decode");
        tail_check("a_hold_low", 16);
        step();
        check_output("a_done_pulse", int'(done), 0);
        check_output("a_result_held", int'(result), 1);

        $display("[TB] single symbol 00000 last");
        sym_tab = '{5'b00000};
        last_tab = '{1'b1};
        apply_stimulus(1, 1'b1, -1);
        check_output("b_done_at", done_at, 1128);
        check_output("b_result", int'(done_result), 1);
        build_expected(1);
        decode_check("b_decode");
        if (line_q.size() > 1103) check_output("b_last_data_high", int'(line_q[1103]), 1);
        tail_check("b_trail_hold_low", 24);

        $display("[TB] three symbols back to back");
        sym_tab = '{5'b10110, 5'b01001, 5'b11100};
        last_tab = '{1'b0, 1'b0, 1'b1};
        apply_stimulus(3, 1'b1, -1);
        check_output("c_ready_count", ready_pos.size(), 3);
        if (ready_pos.size() == 3) begin
            check_output("c_ready0", ready_pos[0], 1023);
            check_output("c_ready1", ready_pos[1], 1103);
            check_output("c_ready2", ready_pos[2], 1183);
        end
        check_output("c_done_at", done_at, 1288);
        check_output("c_result", int'(done_result), 1);
        build_expected(3);
        decode_check("c_decode");
        tail_check("c_trail_hold_low", 24);

        $display("[TB] underrun at first fetch");
        sym_tab = '{5'b10101};
        last_tab = '{1'b1};
        apply_stimulus(1, 1'b0, -1);
        check_output("d_ready_count", ready_pos.size(), 0);
        check_output("d_done_at", done_at, 1040);
        check_output("d_result", int'(done_result), 0);
        tail_check("d_hold_low", 16);

        $display("[TB] start pulse mid-preamble");
        sym_tab = '{5'b11111};
        last_tab = '{1'b1};
        apply_stimulus(1, 1'b1, 500);
        check_output("e_done_at", done_at, 1120);
        check_output("e_result", int'(done_result), 1);

        $display("[TB] reset mid-data");
        sym_tab = '{5'b10101};
        last_tab = '{1'b1};
        sym_idx = 0;
        drive_symbol(1'b1);
        en = 1'b1;
        step();
        en = 1'b0;
        for (int n = 0; n < 1060; n++) step();
        check_output("f_oe_before_reset", int'(oe), 1);
        rst_n = 1'b0;
        #1;
        check_output("f_oe_async", int'(oe), 0);
        check_output("f_cc_async", int'(cc), 0);
        check_output("f_busy_async", int'(busy), 0);
        check_output("f_ready_async", int'(sym_bus.phy_tx_sym_ready), 0);
        check_output("f_result_async", int'(result), 0);
        step();
        rst_n = 1'b1;
        done_count = 0;
        oe_seen = 0;
        for (int n = 0; n < 200; n++) begin
            if (done) done_count++;
            if (oe) oe_seen++;
            step();
        end
        check_output("f_no_done", done_count, 0);
        check_output("f_no_oe", oe_seen, 0);
        sym_bus.phy_tx_sym_valid = 1'b0;

`ifdef PHY_TX_IDLE_GATE_EN
        $display("[TB] line never idle");
        line_idle = 1'b0;
        en = 1'b1;
        step();
        en = 1'b0;
        done_at = -1;
        oe_seen = 0;
        for (int n = 0; n < 700; n++) begin
            if (oe) oe_seen++;
            if (done) begin
                done_at = n;
                done_result = result;
                break;
            end
            step();
        end
        check_output("g_done_at", done_at, 512);
        check_output("g_result", int'(done_result), 0);
        check_output("g_oe_never", oe_seen, 0);
        step();

        $display("[TB] line idle after 100 clk");
        en = 1'b1;
        step();
        en = 1'b0;
        first_oe = -1;
        done_at = -1;
        for (int n = 0; n < 1500; n++) begin
            if (n == 100) begin
                check_output("h_oe_before_idle", int'(oe), 0);
                line_idle = 1'b1;
            end
            if (oe && first_oe < 0) first_oe = n;
            if (done) begin
                done_at = n;
                break;
            end
            step();
        end
        check_output("h_first_oe", first_oe, 101);
        check_output("h_done_at", done_at, 101 + 1040);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end
endmodule
